// File: rtl/fp32_acc_seq.sv
// fp32_acc_seq: streaming FP32 packet reduction sequencer feeding a single
// external fp32_add unit. Holds the running sum, issues one add at a time,
// and emits one sum per packet with its element count and a timeout flag.
module fp32_acc_seq #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_data,
   input  logic             in_last,
   output logic             add_valid,
   output logic [31:0]      add_a,
   output logic [31:0]      add_b,
   input  logic [31:0]      add_y,
   input  logic             add_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             err_timeout
);

   localparam int TMO_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GATHER = 2'd1,
      WAIT   = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t            state;
   logic [31:0]       acc;
   logic [CNT_W-1:0]  count;
   logic [TMO_W-1:0]  tmo;
   logic              last_q;
   logic              in_hs;

   // Input is only accepted while no add is pending and no result is waiting;
   // gated by rst so the port reads 0 during reset.
   assign in_ready  = !rst && ((state == IDLE) || (state == GATHER));
   assign in_hs     = in_valid && in_ready;

   // Result port mirrors the accumulator registers directly.
   assign out_valid = (state == DONE);
   assign out_sum   = acc;
   assign out_count = count;

   // Sequencer FSM: load first element, issue one add per further element,
   // wait for the adder (bounded by TIMEOUT), then present the packet sum.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         acc         <= '0;
         count       <= '0;
         tmo         <= '0;
         last_q      <= 1'b0;
         add_valid   <= 1'b0;
         add_a       <= '0;
         add_b       <= '0;
         err_timeout <= 1'b0;
      end else begin
         add_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (in_hs) begin
                  acc   <= in_data;
                  count <= CNT_W'(1);
                  state <= in_last ? DONE : GATHER;
               end
            end
            GATHER: begin
               if (in_hs) begin
                  add_a     <= acc;
                  add_b     <= in_data;
                  add_valid <= 1'b1;
                  if (count != '1)
                     count <= count + CNT_W'(1);
                  last_q    <= in_last;
                  tmo       <= '0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               // A response on the timeout cycle still wins over the timeout.
               if (add_ready) begin
                  acc   <= add_y;
                  state <= last_q ? DONE : GATHER;
               end else if (tmo == TMO_W'(TIMEOUT - 1)) begin
                  err_timeout <= 1'b1;
                  state       <= DONE;
               end else begin
                  tmo <= tmo + TMO_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  err_timeout <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
